// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction feeder: FSM state encoding
// and the default word that terminates a program.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;

endpackage

// File: rtl/prog_ram.sv
// Program storage for the feeder: synchronous write, combinational read,
// deliberately unreset so a loaded program survives a feeder reset.
module prog_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_feeder.sv
// Self-paced instruction source: issues one program word per processor
// completion, halting on HALT_WORD, end of memory, or a completion timeout.
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter int          TIMEOUT   = 64
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          start,
    input  logic          done,
    output logic [15:0]   iin,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e        state_q, state_d;
    logic [15:0]   iin_q, iin_d;
    logic          run_q, run_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ram_we;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;

    // Only one word is ever needed: mem[0] when starting, mem[pc+1] while waiting.
    assign ram_we  = wr_en && ((state_q == IDLE) || (state_q == HALT));
    assign rd_addr = (state_q == WAIT) ? pc_q + AW'(1) : '0;

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clock_i (clock),
        .we_i    (ram_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            iin_q   <= '0;
            run_q   <= 1'b0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            iin_q   <= iin_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is cleared on entry to ISSUE and counts every cycle after,
    // so it reads TIMEOUT-1 in the last WAIT cycle before the deadline.
    always_comb begin
        state_d = state_q;
        iin_d   = iin_q;
        run_d   = 1'b0;
        pc_d    = pc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    err_d = 1'b0;
                    pc_d  = '0;
                    cnt_d = '0;
                    if (rd_data == HALT_WORD) begin
                        state_d = HALT;
                    end else begin
                        iin_d   = rd_data;
                        run_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = cnt_q + CW'(1);
            end
            WAIT: begin
                if (done) begin
                    cnt_d = '0;
                    if (pc_q == AW'(DEPTH - 1)) begin
                        state_d = HALT;
                    end else if (rd_data == HALT_WORD) begin
                        pc_d    = pc_q + AW'(1);
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        iin_d   = rd_data;
                        run_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign iin    = iin_q;
    assign run    = run_q;
    assign pc     = pc_q;
    assign err    = err_q;
    assign busy   = (state_q == ISSUE) || (state_q == WAIT);
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: expected issued words are queued as
// stimulus is applied and a negedge monitor matches every run pulse.
module tb_instr_feeder;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        done;
    logic [15:0] iin;
    logic        run;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;

    typedef struct {
        logic [15:0] iin;
        logic [3:0]  pc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   runCount = 0;

    instr_feeder dut (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .done    (done),
        .iin     (iin),
        .run     (run),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .err     (err)
    );

    always #5 clock = ~clock;

    // Every run pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (resetn && run) begin
            runCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL run_unexpected: got iin=%h pc=%0d, required no run pulse", iin, pc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (iin !== e.iin || pc !== e.pc) begin
                    errors++;
                    $display("[TB] FAIL run_word: got iin=%h pc=%0d, required iin=%h pc=%0d",
                             iin, pc, e.iin, e.pc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs starting at a negedge, then returns at the next negedge.
    task automatic applyStimulus(input logic doWr, input logic [3:0] a, input logic [15:0] d,
                                 input logic doStart, input logic doDone);
        wr_en   = doWr;
        wr_addr = a;
        wr_data = d;
        start   = doStart;
        done    = doDone;
        @(negedge clock);
        wr_en = 1'b0;
        start = 1'b0;
        done  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic waitRun(input string name, input int maxCycles);
        int n = 0;
        while (!run && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, {31'd0, run}, 32'd1);
    endtask

    task automatic expectWord(input logic [15:0] w, input logic [3:0] p);
        exp_t e;
        e.iin = w;
        e.pc  = p;
        expQ.push_back(e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int runsBefore;
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; done = 1'b0;
        tick(2);
        checkOutput("reset_iin",    {16'd0, iin}, 32'h0);
        checkOutput("reset_run",    {31'd0, run}, 32'd0);
        checkOutput("reset_pc",     {28'd0, pc}, 32'd0);
        checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_err",    {31'd0, err}, 32'd0);
        resetn = 1'b1;
        tick(1);

        $display("[TB] normal run");
        applyStimulus(1'b1, 4'd0, 16'hA022, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 16'h0080, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 16'hA83E, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 16'hFFFF, 1'b0, 1'b0);
        expectWord(16'hA022, 4'd0);
        expectWord(16'h0080, 4'd1);
        expectWord(16'hA83E, 4'd2);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            waitRun("normal_run", 10);
            tick(2);
            applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        end
        checkOutput("normal_halted", {31'd0, halted}, 32'd1);
        checkOutput("normal_pc",     {28'd0, pc}, 32'd3);
        checkOutput("normal_err",    {31'd0, err}, 32'd0);
        checkOutput("normal_iin",    {16'd0, iin}, 32'h0000A83E);
        checkOutput("normal_busy",   {31'd0, busy}, 32'd0);

        $display("[TB] immediate halt");
        applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0);
        runsBefore = runCount;
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("imm_halted", {31'd0, halted}, 32'd1);
        checkOutput("imm_pc",     {28'd0, pc}, 32'd0);
        tick(3);
        checkOutput("imm_no_run", runCount, runsBefore);

        $display("[TB] end of memory");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 1'b0);
            expectWord(16'h1000 + 16'(i), 4'(i));
        end
        runsBefore = runCount;
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            waitRun("eom_run", 10);
            tick(1);
            applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        end
        checkOutput("eom_halted", {31'd0, halted}, 32'd1);
        checkOutput("eom_pc",     {28'd0, pc}, 32'd15);
        checkOutput("eom_runs",   runCount - runsBefore, 32'd16);

        $display("[TB] timeout");
        applyStimulus(1'b1, 4'd0, 16'h2222, 1'b0, 1'b0);
        expectWord(16'h2222, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        waitRun("to_run", 2);
        cycles = 0;
        while (!halted && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("to_cycles", cycles, 32'd64);
        checkOutput("to_err",    {31'd0, err}, 32'd1);
        expectWord(16'h2222, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("restart_run",  {31'd0, run}, 32'd1);
        checkOutput("restart_err",  {31'd0, err}, 32'd0);
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);

        $display("[TB] ignored inputs");
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("issue_done_pc",   {28'd0, pc}, 32'd0);
        checkOutput("issue_done_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b1, 4'd1, 16'hDEAD, 1'b1, 1'b0);
        checkOutput("wait_start_run", {31'd0, run}, 32'd0);
        checkOutput("wait_start_pc",  {28'd0, pc}, 32'd0);
        expectWord(16'h1001, 4'd1);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        waitRun("mem1_run", 2);

        $display("[TB] reset mid-run");
        tick(1);
        expectWord(16'h1002, 4'd2);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        waitRun("pc2_run", 2);
        tick(1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_iin",    {16'd0, iin}, 32'h0);
        checkOutput("rst_pc",     {28'd0, pc}, 32'd0);
        checkOutput("rst_run",    {31'd0, run}, 32'd0);
        checkOutput("rst_busy",   {31'd0, busy}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_err",    {31'd0, err}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        tick(1);
        expectWord(16'h2222, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        waitRun("retained_run", 2);
        tick(2);
        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction source for `processor`: stores a small program and presents one 16-bit word at a time on the processor's `iin` input. It advances only when the processor signals completion, which replaces hand-timed stimulus with a self-paced handshake. It sits beside `processor` in the top level and in benches, and is loaded through a simple write port while stopped.

## Interface
- `DEPTH`, 16: program words; power of two.
- `AW`, 4: address width, $clog2(DEPTH).
- `HALT_WORD`, 16'hFFFF: word that stops execution and is never issued.
- `TIMEOUT`, 64: maximum cycles in WAIT before an error halt.

- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  16  write data.
- `start`  in  1  level-sampled start request.
- `done`  in  1  one-cycle pulse from the processor: the current instruction has completed.
- `iin`  out  16  instruction word to the processor; registered.
- `run`  out  1  one-cycle pulse: a new word is valid on `iin` this cycle.
- `pc`  out  AW  address of the word on `iin`.
- `busy`  out  1  high in ISSUE and WAIT.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky timeout flag, cleared by `start` or reset.

## Operation
- States: IDLE, ISSUE, WAIT, HALT.
- Reset (asynchronous, any state): state IDLE; `iin`=0, `run`=0, `pc`=0, `busy`=0, `halted`=0, `err`=0, timeout counter 0. Program memory is not reset.
- Writes apply only in IDLE or HALT. `wr_en` in ISSUE or WAIT is ignored.
- IDLE or HALT with `start`=1:
  - If mem[0]==HALT_WORD: go to HALT, `pc`=0, no `run` pulse.
  - Otherwise: `pc`=0, `iin`=mem[0], `run`=1, `err`=0, state ISSUE.
- ISSUE: unconditionally go to WAIT next edge; `run`=0, counter=0. `done` in ISSUE is ignored.
- WAIT: `iin` and `pc` hold; counter increments each cycle. On `done`=1:
  - If `pc`==DEPTH-1: go to HALT.
  - Else if mem[pc+1]==HALT_WORD: go to HALT with `pc`=pc+1; `iin` holds the old word.
  - Else: `pc`=pc+1, `iin`=mem[pc+1], `run`=1, state ISSUE.
- WAIT with counter==TIMEOUT-1 and no `done`: go to HALT, `err`=1.
- If `done` arrives in the same cycle the counter reaches its limit, `done` wins.
- `start` in ISSUE or WAIT is ignored. `done` in IDLE or HALT is ignored.
- `pc` never wraps. The end of memory always halts.

## Timing
- `start` sampled at edge N: `run`=1 and `iin` valid in cycle N+1.
- `done` sampled at edge M: next `run` pulse in cycle M+1. Handshake overhead is 1 cycle per instruction; minimum issue period is 2 cycles.
- Memory read is combinational, so the next word is selected and registered on the same edge that `done` is sampled.
- `busy` and `halted` are decoded from the state register; there is no extra latency.
- Timeout fires TIMEOUT cycles after the ISSUE cycle.

## Structure
- Package `feeder_pkg`: state enum (IDLE, ISSUE, WAIT, HALT) and the default HALT_WORD constant.
- Sub-module `prog_ram`: DEPTH x 16 storage with synchronous write and asynchronous read, no reset. The FSM, `pc` and timeout counter live in `instr_feeder`.

## Test plan
- Normal run:
  - Stimulus: load 16'hA022, 16'h0080, 16'hA83E, 16'hFFFF; `start`; `done` 3 cycles after each `run`.
  - Required: `run` pulses with `iin`=A022, 0080, A83E and `pc`=0, 1, 2; then `halted`=1, `pc`=3, `err`=0.
- Immediate halt:
  - Stimulus: mem[0]=16'hFFFF; `start`.
  - Required: HALT on the next edge; `run` never asserted.
- End of memory:
  - Stimulus: all 16 words non-halt; `done` after each `run`.
  - Required: 16 `run` pulses; HALT with `pc`=15.
- Timeout:
  - Stimulus: `start`; never assert `done`.
  - Required: `halted`=1 and `err`=1 exactly 64 cycles after the `run` cycle. A following `start` clears `err` and reissues mem[0].
- Ignored inputs:
  - Stimulus: `wr_en` to addr 1 and `start` during WAIT; `done` during ISSUE.
  - Required: mem[1] unchanged, no restart, `pc` does not advance.
- Reset mid-run:
  - Stimulus: `resetn`=0 during WAIT at `pc`=2.
  - Required: all outputs go to reset values immediately. A following `start` issues mem[0], proving memory contents are retained.
